// File: rtl/snurisc_mem_arbiter.sv
// Single-port SRAM arbiter for the snurisc loader, data port and instruction fetch.
// Optional macro SNURISC_ARB_STARVE_GUARD_EN promotes a starved fetch above the data port.
module snurisc_mem_arbiter #(
    parameter int AW         = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clock_en,
    input  logic          i_ld_req,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [31:0]   i_ld_wdata,
    input  logic [3:0]    i_ld_wstrb,
    output logic          o_ld_gnt,
    output logic          o_ld_rvalid,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    input  logic [3:0]    i_d_wstrb,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [31:0]   o_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_wstrb,
    input  logic [31:0]   i_mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_IF   = 2'd3
    } owner_t;

    owner_t owner_q;
    owner_t owner_d;
    logic   ld_gnt;
    logic   d_gnt;
    logic   if_gnt;
    logic   if_promoted;

`ifdef SNURISC_ARB_STARVE_GUARD_EN
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q;

    assign if_promoted = (starve_q == CW'(STARVE_MAX));

    // Counts enabled cycles in which fetch waited; a withdrawn or served fetch starts over.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_q <= '0;
        end else if (!i_if_req || if_gnt) begin
            starve_q <= '0;
        end else if (i_clock_en && !if_promoted) begin
            starve_q <= starve_q + CW'(1);
        end
    end
`else
    assign if_promoted = 1'b0;
`endif

    // Grants are combinational so the winner completes on this edge.
    always_comb begin
        ld_gnt = 1'b0;
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (i_clock_en && i_reset) begin
            if (i_ld_req) begin
                ld_gnt = 1'b1;
            end else if (if_promoted && i_if_req) begin
                if_gnt = 1'b1;
            end else if (i_d_req) begin
                d_gnt = 1'b1;
            end else if (i_if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        if (ld_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_ld_we;
            o_mem_addr  = i_ld_addr;
            o_mem_wdata = i_ld_wdata;
            o_mem_wstrb = i_ld_wstrb;
        end else if (d_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_wstrb = i_d_wstrb;
        end else if (if_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_if_addr;
        end
    end

    // Response owner: remembers who issued the read whose data returns next cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (ld_gnt && !i_ld_we) begin
            owner_d = OWN_LD;
        end else if (d_gnt && !i_d_we) begin
            owner_d = OWN_D;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
    end

    always_comb begin
        o_ld_gnt    = ld_gnt;
        o_d_gnt     = d_gnt;
        o_if_gnt    = if_gnt;
        o_ld_rvalid = (owner_q == OWN_LD);
        o_d_rvalid  = (owner_q == OWN_D);
        o_if_rvalid = (owner_q == OWN_IF);
        o_rdata     = (owner_q != OWN_NONE) ? i_mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_snurisc_mem_arbiter.sv
// Bench for snurisc_mem_arbiter: SRAM environment, cycle-level reference model and directed vectors.
module tb_snurisc_mem_arbiter;

    localparam int AW         = 12;
    localparam int STARVE_MAX = 4;
`ifdef SNURISC_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clock_en = 1'b0;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_wdata = '0;
    logic [3:0]    ld_wstrb = '0;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          ld_gnt, ld_rvalid, d_gnt, d_rvalid, if_gnt, if_rvalid;
    logic [31:0]   rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snurisc_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_clock_en(clock_en),
        .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr),
        .i_ld_wdata(ld_wdata), .i_ld_wstrb(ld_wstrb),
        .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
        .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_rdata(mem_rdata)
    );

    // SRAM environment driven purely by the DUT's memory port.
    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: winner = 0 none, 1 ld, 2 d, 3 if; one pending read returns next cycle.
    int          exp_owner = 0;
    logic [31:0] exp_data = '0;
    int          starve_cnt = 0;

    always @(negedge clk) begin : model
        int          win;
        logic [31:0] e_addr, e_wdata, e_wstrb;
        logic        e_we;
        if (!rst_n) begin
            exp_owner  = 0;
            starve_cnt = 0;
        end
        check_output("ld_rvalid", 32'(ld_rvalid), 32'(exp_owner == 1));
        check_output("d_rvalid",  32'(d_rvalid),  32'(exp_owner == 2));
        check_output("if_rvalid", 32'(if_rvalid), 32'(exp_owner == 3));
        check_output("rdata", rdata, (exp_owner != 0) ? exp_data : 32'd0);

        win = 0;
        if (rst_n && clock_en) begin
            if (ld_req) win = 1;
            else if (GUARD && starve_cnt >= STARVE_MAX && if_req) win = 3;
            else if (d_req) win = 2;
            else if (if_req) win = 3;
        end
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        case (win)
            1: begin e_we = ld_we; e_addr = 32'(ld_addr); e_wdata = ld_wdata; e_wstrb = 32'(ld_wstrb); end
            2: begin e_we = d_we;  e_addr = 32'(d_addr);  e_wdata = d_wdata;  e_wstrb = 32'(d_wstrb);  end
            3: begin e_addr = 32'(if_addr); end
            default: ;
        endcase
        check_output("ld_gnt", 32'(ld_gnt), 32'(win == 1));
        check_output("d_gnt",  32'(d_gnt),  32'(win == 2));
        check_output("if_gnt", 32'(if_gnt), 32'(win == 3));
        check_output("mem_en", 32'(mem_en), 32'(win != 0));
        check_output("mem_we", 32'(mem_we), 32'(e_we));
        check_output("mem_addr", 32'(mem_addr), e_addr);
        if (win != 3) begin
            check_output("mem_wdata", mem_wdata, e_wdata);
            check_output("mem_wstrb", 32'(mem_wstrb), e_wstrb);
        end

        exp_owner = 0;
        if (win != 0) begin
            if (e_we) begin
                for (int b = 0; b < 4; b++)
                    if (e_wstrb[b]) ref_mem[e_addr[AW-1:0]][b*8 +: 8] = e_wdata[b*8 +: 8];
            end else begin
                exp_owner = win;
                exp_data  = ref_mem[e_addr[AW-1:0]];
            end
        end
        if (!rst_n || !if_req || win == 3) starve_cnt = 0;
        else if (clock_en && starve_cnt < STARVE_MAX) starve_cnt++;
    end

    // Sets all requester inputs just after a rising edge, then waits to the sampling edge.
    task automatic apply_stimulus(
        input logic en,
        input logic lr, input logic lw, input logic [AW-1:0] la, input logic [31:0] lwd, input logic [3:0] ls,
        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [31:0] dwd, input logic [3:0] ds,
        input logic ir, input logic [AW-1:0] ia);
        @(posedge clk);
        #1;
        clock_en = en;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_wstrb = ls;
        d_req = dr;  d_we = dw;  d_addr = da;  d_wdata = dwd;  d_wstrb = ds;
        if_req = ir; if_addr = ia;
        @(negedge clk);
    endtask

    task automatic idle(input logic en);
        apply_stimulus(en, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    initial begin
        int first_if;
        $display("[TB] start, starvation guard = %0d", GUARD);

        idle(1); idle(1); idle(1);
        check_output("reset_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_rdata", rdata, 32'd0);
        check_output("idle_gnts", 32'({ld_gnt, d_gnt, if_gnt}), 32'd0);

        apply_stimulus(1, 1, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0, 0, '0);
        check_output("ld_wr_gnt", 32'(ld_gnt), 32'd1);
        check_output("ld_wr_we", 32'(mem_we), 32'd1);
        apply_stimulus(1, 1, 0, 12'h010, '0, '0, 0, 0, '0, '0, '0, 0, '0);
        idle(1);
        check_output("ld_rd_rvalid", 32'(ld_rvalid), 32'd1);
        check_output("ld_rd_data", rdata, 32'hDEADBEEF);

        apply_stimulus(1, 1, 0, 12'h001, '0, '0, 1, 0, 12'h002, '0, '0, 1, 12'h003);
        check_output("conflict_ld_first", 32'(ld_gnt), 32'd1);
        apply_stimulus(1, 0, 0, '0, '0, '0, 1, 0, 12'h002, '0, '0, 1, 12'h003);
        check_output("conflict_d_second", 32'(d_gnt), 32'd1);
        check_output("conflict_ld_data", rdata, 32'hA500_0001);
        apply_stimulus(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 12'h003);
        check_output("conflict_if_third", 32'(if_gnt), 32'd1);
        check_output("conflict_d_data", rdata, 32'hA500_0002);
        idle(1);
        check_output("conflict_if_rvalid", 32'(if_rvalid), 32'd1);
        check_output("conflict_if_data", rdata, 32'hA500_0003);

        apply_stimulus(1, 0, 0, '0, '0, '0, 1, 0, 12'h020, '0, '0, 0, '0);
        apply_stimulus(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 12'h021);
        check_output("ce_low_d_rvalid", 32'(d_rvalid), 32'd1);
        check_output("ce_low_d_data", rdata, 32'hA500_0020);
        check_output("ce_low_if_held", 32'(if_gnt), 32'd0);
        apply_stimulus(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 12'h021);
        apply_stimulus(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 12'h021);
        check_output("ce_back_if_gnt", 32'(if_gnt), 32'd1);
        idle(1);
        check_output("ce_if_data", rdata, 32'hA500_0021);

        first_if = 0;
        for (int c = 1; c <= 8; c++) begin
            apply_stimulus(1, 0, 0, '0, '0, '0, 1, 0, 12'h030, '0, '0, 1, 12'h031);
            if (if_gnt && first_if == 0) first_if = c;
        end
`ifdef SNURISC_ARB_STARVE_GUARD_EN
        check_output("starve_first_if_cycle", 32'(first_if), 32'd5);
`else
        check_output("no_guard_if_never", 32'(first_if), 32'd0);
`endif
        idle(1);

        apply_stimulus(1, 0, 0, '0, '0, '0, 1, 1, 12'h050, 32'h11223344, 4'h5, 0, '0);
        apply_stimulus(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 12'h050);
        idle(1);
        check_output("strobe_merge_data", rdata, 32'hA522_0044);

        apply_stimulus(1, 0, 0, '0, '0, '0, 1, 0, 12'h040, '0, '0, 0, '0);
        check_output("rst_mid_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_mid_rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_release_rvalid", 32'(d_rvalid), 32'd0);
        check_output("rst_release_rdata", rdata, 32'd0);
        idle(1); idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snurisc_mem_arbiter.md
Name: snurisc_mem_arbiter

Overview:
- Arbitrates one single-port synchronous SRAM between three requesters of the snurisc core: image loader (ld), data port (d) and instruction fetch (if).
- The loader preloads the program image before run. The core's D-side and I-side then share the same SRAM.
- Issues at most one memory access per enabled cycle and routes the 1-cycle-latency read data back to its owner.

Parameters:
- AW, 12, word-address width of the SRAM (4096 x 32-bit words).
- STARVE_MAX, 4, consecutive denied if-request cycles before if is promoted (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-low
- i_clock_en  in  1  global enable; low = no new grants
- i_ld_req  in  1  loader request
- i_ld_we  in  1  loader write (1) / read (0)
- i_ld_addr  in  AW  loader word address
- i_ld_wdata  in  32  loader write data
- i_ld_wstrb  in  4  loader byte strobes
- o_ld_gnt  out  1  loader granted this cycle
- o_ld_rvalid  out  1  loader read data valid on o_rdata
- i_d_req, i_d_we  in  1 each  data-port request, write
- i_d_addr  in  AW  data word address
- i_d_wdata  in  32  data write data
- i_d_wstrb  in  4  data byte strobes
- o_d_gnt, o_d_rvalid  out  1 each  data-port grant, read valid
- i_if_req  in  1  fetch request (read-only)
- i_if_addr  in  AW  fetch word address
- o_if_gnt, o_if_rvalid  out  1 each  fetch grant, read valid
- o_rdata  out  32  shared read-data return bus
- o_mem_en  out  1  SRAM access enable
- o_mem_we  out  1  SRAM write enable
- o_mem_addr  out  AW  SRAM address
- o_mem_wdata  out  32  SRAM write data
- o_mem_wstrb  out  4  SRAM byte strobes
- i_mem_rdata  in  32  SRAM read data, valid the cycle after an enabled read

Behaviour:
- **Reset:** i_reset low clears every registered output and state to 0 asynchronously: rvalids, o_rdata, response owner, starvation counter. Grants and o_mem_* are 0 while in reset.
- **Grant rules:**
  - Grants are combinational from the requests and current state.
  - Exactly one or zero grants per cycle, and only when i_clock_en = 1.
  - A requester holds req and its address/data until it sees gnt in the same cycle. The transfer completes on that edge.
- **Priority:** fixed ld > d > if.
- **Memory drive:**
  - On a grant, o_mem_en = 1 and o_mem_we, addr, wdata and wstrb are muxed from the winner. For if, o_mem_we = 0.
  - With no grant, o_mem_en = 0 and the other o_mem_* outputs are 0.
- **Read response:**
  - A granted read registers its owner (ld/d/if) and a pending flag.
  - Next cycle: the owner's rvalid = 1 for exactly one cycle, and o_rdata = i_mem_rdata, registered to appear in that same cycle.
  - Writes produce no rvalid.
  - Back-to-back reads from different requesters give back-to-back rvalids in grant order. Throughput is 1 access per cycle.
- **Clock enable:** i_clock_en falling with a read outstanding still delivers its rvalid the next cycle. No new grants are issued while the enable is low.
- **Simultaneous requests:** only the winner sees gnt. Losers keep req asserted and are unaffected.
- **Reset mid-operation:** an outstanding response is discarded; no rvalid follows reset release.
- **Address width:** no range check; addresses wrap naturally within AW bits.

Optional Feature:
- Macro: SNURISC_ARB_STARVE_GUARD_EN.
- **Defined:**
  - A counter increments each enabled cycle in which i_if_req = 1 and if is not granted. It saturates at STARVE_MAX.
  - At STARVE_MAX the effective priority becomes ld > if > d.
  - The counter clears on an if grant or when i_if_req = 0.
- **Undefined:** pure fixed priority and no counter logic.

Test Plan:
- **Reset and idle:** hold i_reset = 0 for 3 cycles, then release with no requests -> all gnt, rvalid, o_mem_en and o_rdata = 0.
- **Loader write/read:**
  - Loader writes addr 0x010 data 0xDEADBEEF, wstrb 0xF -> o_ld_gnt = 1, o_mem_we = 1 in the same cycle.
  - Loader then reads addr 0x010 -> o_ld_rvalid = 1 one cycle later with o_rdata = 0xDEADBEEF.
- **Three-way conflict:** ld, d and if all request reads of 0x001, 0x002 and 0x003 in the same cycle.
  - Grants arrive over 3 consecutive cycles: ld, then d, then if.
  - rvalids follow one cycle behind in the same order, with the matching SRAM words.
- **Clock-enable gating:**
  - d read granted, then i_clock_en drops -> o_d_rvalid still asserts the next cycle.
  - A pending if_req is not granted until i_clock_en returns to 1.
- **Starvation (macro on):** d requests continuously and if requests continuously.
  - if is granted on the 5th cycle (after 4 denials).
  - With the macro off, if is never granted while d requests.
- **Async reset mid-read:** drop i_reset in the cycle after a d read grant -> o_d_rvalid stays 0 and o_rdata = 0 after release.
